// File: rtl/exc_ctrl_unit_if.sv
// Exception controller bus: decoder/IRQ/PC inputs, redirect/control outputs,
// system-register views and MRS read port.
//   master : the core side (drives decoder/IRQ/PC/sel, observes controls)
//   slave  : exc_ctrl_unit
interface exc_ctrl_unit_if #(
  parameter int unsigned N = 64
);
  logic         exc;
  logic [3:0]   estatus;
  logic         eret;
  logic         ext_irq;
  logic [N-1:0] pc;
  logic [1:0]   sysreg_sel;

  logic         pc_redirect;
  logic [N-1:0] redirect_target;
  logic         squash;
  logic         stall;
  logic         irq_ack;
  logic         in_handler;
  logic         double_fault;
  logic [N-1:0] elr;
  logic [3:0]   esr;
  logic [N-1:0] sysreg_rdata;

  modport master (
    output exc, estatus, eret, ext_irq, pc, sysreg_sel,
    input  pc_redirect, redirect_target, squash, stall, irq_ack,
           in_handler, double_fault, elr, esr, sysreg_rdata
  );

  modport slave (
    input  exc, estatus, eret, ext_irq, pc, sysreg_sel,
    output pc_redirect, redirect_target, squash, stall, irq_ack,
           in_handler, double_fault, elr, esr, sysreg_rdata
  );
endinterface

// File: rtl/exc_ctrl_unit.sv
// Exception controller for the single-cycle LEGv8 core.
// Holds ELR/ESR/ERR and a RUN/HANDLER/HALT FSM; redirects the PC to the
// exception vector or the return address, squashes the committing instruction
// and serves MRS reads.
// Ports:
//   clk   : core clock, rising-edge state updates
//   reset : synchronous, active-high
//   bus   : exc_ctrl_unit_if.slave (exc, estatus, eret, ext_irq, pc,
//           sysreg_sel in; pc_redirect, redirect_target, squash, stall,
//           irq_ack, in_handler, double_fault, elr, esr, sysreg_rdata out)
module exc_ctrl_unit #(
  parameter int unsigned  N           = 64,
  parameter logic [N-1:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8,
  parameter int unsigned  CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  exc_ctrl_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [3:0] ESR_IRQ = 4'b0001;
  localparam logic [3:0] ESR_INV = 4'b0010;
  localparam logic [3:0] ESR_DBL = 4'b0011;

  state_t           state_q;
  logic [N-1:0]     elr_q;
  logic [3:0]       esr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             irq_pending_q;

  logic             inv;
  logic             irq_take;
  logic [CNT_W-1:0] cnt_d;
  logic             irq_pending_d;

  assign inv      = bus.exc && (bus.estatus == ESR_INV);
  // An invalid opcode wins over an IRQ; the IRQ then stays pending.
  assign irq_take = (state_q == RUN) && !inv && (irq_pending_q || bus.ext_irq);
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // A still-high request re-arms pending even in the cycle it is taken.
  always_comb begin
    irq_pending_d = irq_pending_q;
    if (irq_take)    irq_pending_d = 1'b0;
    if (bus.ext_irq) irq_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      elr_q         <= '0;
      esr_q         <= '0;
      cnt_q         <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_pending_q <= irq_pending_d;
      unique case (state_q)
        RUN: begin
          if (inv) begin
            elr_q   <= bus.pc;
            esr_q   <= ESR_INV;
            cnt_q   <= cnt_d;
            state_q <= HANDLER;
          end else if (irq_take) begin
            elr_q   <= bus.pc;
            esr_q   <= ESR_IRQ;
            cnt_q   <= cnt_d;
            state_q <= HANDLER;
          end
        end
        HANDLER: begin
          if (inv) begin
            esr_q   <= ESR_DBL;
            state_q <= HALT;
          end else if (bus.eret) begin
            state_q <= RUN;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_redirect     = 1'b0;
    bus.redirect_target = '0;
    bus.squash          = 1'b0;
    bus.irq_ack         = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (inv) begin
            bus.pc_redirect     = 1'b1;
            bus.redirect_target = VECTOR_ADDR;
          end else if (irq_take) begin
            bus.pc_redirect     = 1'b1;
            bus.redirect_target = VECTOR_ADDR;
            bus.squash          = 1'b1;
            bus.irq_ack         = 1'b1;
          end else if (bus.eret) begin
            bus.pc_redirect     = 1'b1;
            bus.redirect_target = elr_q;
          end
        end
        HANDLER: begin
          if (inv) begin
            bus.squash = 1'b1;
          end else if (bus.eret) begin
            bus.pc_redirect     = 1'b1;
            bus.redirect_target = elr_q;
          end
        end
        HALT:    bus.squash = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.stall        = (state_q == HALT);
  assign bus.double_fault = (state_q == HALT);
  assign bus.in_handler   = (state_q == HANDLER);
  assign bus.elr          = elr_q;
  assign bus.esr          = esr_q;

  always_comb begin
    bus.sysreg_rdata = '0;
    unique case (bus.sysreg_sel)
      2'b00:   bus.sysreg_rdata = elr_q;
      2'b01:   bus.sysreg_rdata = {{(N-4){1'b0}}, esr_q};
      2'b10:   bus.sysreg_rdata = {{(N-CNT_W){1'b0}}, cnt_q};
      default: bus.sysreg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl_unit.sv
module tb_exc_ctrl_unit;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exc_ctrl_unit_if #(.N(64)) bus ();
  exc_ctrl_unit_if #(.N(64)) bus4 ();

  exc_ctrl_unit #(.N(64), .VECTOR_ADDR(64'hD8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  exc_ctrl_unit #(.N(64), .VECTOR_ADDR(64'hD8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a falling edge; outputs are sampled 1 ns later.
  task automatic drv(input logic e, input logic [3:0] es, input logic r,
                     input logic q, input logic [63:0] p);
    @(negedge clk);
    bus.exc = e; bus.estatus = es; bus.eret = r; bus.ext_irq = q; bus.pc = p;
    #1;
  endtask

  task automatic drv4(input logic e, input logic r);
    @(negedge clk);
    bus4.exc = e; bus4.estatus = 4'b0010; bus4.eret = r;
    #1;
  endtask

  initial begin
    bus.exc = 0; bus.estatus = 0; bus.eret = 0; bus.ext_irq = 0; bus.pc = 0; bus.sysreg_sel = 2'b10;
    bus4.exc = 0; bus4.estatus = 0; bus4.eret = 0; bus4.ext_irq = 0; bus4.pc = 64'h10; bus4.sysreg_sel = 2'b10;
    reset = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
    #1;
    chk("rst_in_handler", bus.in_handler, 0);
    chk("rst_elr", bus.elr, 0);
    chk("rst_esr", bus.esr, 0);
    chk("rst_cnt", bus.sysreg_rdata, 0);
    chk("rst_redirect", bus.pc_redirect, 0);
    chk("rst_stall", bus.stall, 0);

    // Invalid opcode in RUN
    drv(1, 4'b0010, 0, 0, 64'h40);
    chk("inv_redirect", bus.pc_redirect, 1);
    chk("inv_target", bus.redirect_target, 64'hD8);
    chk("inv_squash", bus.squash, 0);
    chk("inv_ack", bus.irq_ack, 0);
    drv(0, 0, 0, 0, 64'hD8);
    chk("inv_elr", bus.elr, 64'h40);
    chk("inv_esr", bus.esr, 2);
    chk("inv_in_handler", bus.in_handler, 1);
    chk("inv_mrs_err", bus.sysreg_rdata, 1);
    bus.sysreg_sel = 2'b01; #1;
    chk("inv_mrs_esr", bus.sysreg_rdata, 2);
    bus.sysreg_sel = 2'b00; #1;
    chk("inv_mrs_elr", bus.sysreg_rdata, 64'h40);
    bus.sysreg_sel = 2'b11; #1;
    chk("mrs_zero", bus.sysreg_rdata, 0);
    bus.sysreg_sel = 2'b10;
    drv(0, 0, 1, 0, 64'hDC);
    chk("eret1_redirect", bus.pc_redirect, 1);
    chk("eret1_target", bus.redirect_target, 64'h40);
    drv(0, 0, 0, 0, 64'h40);
    chk("eret1_in_handler", bus.in_handler, 0);
    chk("eret1_redirect_off", bus.pc_redirect, 0);

    // IRQ in RUN; the pulse is still high in the take cycle, so it re-arms
    drv(0, 0, 0, 1, 64'h100);
    chk("irq_ack", bus.irq_ack, 1);
    chk("irq_squash", bus.squash, 1);
    chk("irq_target", bus.redirect_target, 64'hD8);
    drv(0, 0, 0, 0, 64'hD8);
    chk("irq_elr", bus.elr, 64'h100);
    chk("irq_esr", bus.esr, 1);
    chk("irq_cnt", bus.sysreg_rdata, 2);
    chk("irq_in_handler", bus.in_handler, 1);
    drv(0, 0, 1, 0, 64'hDC);
    chk("irq_eret_target", bus.redirect_target, 64'h100);
    drv(0, 0, 0, 0, 64'h104);
    chk("rearm_in_handler", bus.in_handler, 0);
    chk("rearm_ack", bus.irq_ack, 1);
    drv(0, 0, 0, 0, 64'hD8);
    chk("rearm_elr", bus.elr, 64'h104);
    chk("rearm_cnt", bus.sysreg_rdata, 3);
    drv(0, 0, 1, 0, 64'hDC);
    drv(0, 0, 0, 0, 64'h104);
    chk("idle_ack", bus.irq_ack, 0);
    chk("idle_redirect", bus.pc_redirect, 0);

    // IRQ arriving in HANDLER is held until return
    drv(1, 4'b0010, 0, 0, 64'h200);
    drv(0, 0, 0, 1, 64'hD8);
    chk("hirq_redirect", bus.pc_redirect, 0);
    chk("hirq_ack", bus.irq_ack, 0);
    drv(0, 0, 1, 0, 64'hDC);
    chk("hirq_eret_target", bus.redirect_target, 64'h200);
    chk("hirq_eret_ack", bus.irq_ack, 0);
    drv(0, 0, 0, 0, 64'h204);
    chk("hirq_taken_ack", bus.irq_ack, 1);
    chk("hirq_taken_target", bus.redirect_target, 64'hD8);
    drv(0, 0, 0, 0, 64'hD8);
    chk("hirq_esr", bus.esr, 1);
    chk("hirq_elr", bus.elr, 64'h204);
    chk("hirq_cnt", bus.sysreg_rdata, 5);
    drv(0, 0, 1, 0, 64'hDC);
    drv(0, 0, 0, 0, 64'h204);
    chk("hirq_done_ack", bus.irq_ack, 0);

    // Coincident invalid opcode and IRQ
    drv(1, 4'b0010, 0, 1, 64'h300);
    chk("coin_ack", bus.irq_ack, 0);
    chk("coin_squash", bus.squash, 0);
    chk("coin_target", bus.redirect_target, 64'hD8);
    drv(0, 0, 0, 0, 64'hD8);
    chk("coin_esr", bus.esr, 2);
    chk("coin_elr", bus.elr, 64'h300);
    drv(0, 0, 1, 0, 64'hDC);
    drv(0, 0, 0, 0, 64'h304);
    chk("coin_irq_ack", bus.irq_ack, 1);
    drv(0, 0, 0, 0, 64'hD8);
    chk("coin_irq_esr", bus.esr, 1);
    chk("coin_cnt", bus.sysreg_rdata, 7);
    drv(0, 0, 1, 0, 64'hDC);

    // Double fault -> HALT
    drv(1, 4'b0010, 0, 0, 64'h400);
    drv(1, 4'b0010, 0, 0, 64'hD8);
    chk("dbl_squash", bus.squash, 1);
    chk("dbl_redirect", bus.pc_redirect, 0);
    drv(0, 0, 1, 1, 64'hDC);
    chk("halt_stall", bus.stall, 1);
    chk("halt_df", bus.double_fault, 1);
    chk("halt_esr", bus.esr, 3);
    chk("halt_elr", bus.elr, 64'h400);
    chk("halt_eret_ignored", bus.pc_redirect, 0);
    chk("halt_cnt", bus.sysreg_rdata, 8);
    drv(0, 0, 0, 0, 64'hDC);
    chk("halt_hold", bus.stall, 1);
    chk("halt_in_handler", bus.in_handler, 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("reset_redirect", bus.pc_redirect, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rec_stall", bus.stall, 0);
    chk("rec_df", bus.double_fault, 0);
    chk("rec_elr", bus.elr, 0);
    chk("rec_esr", bus.esr, 0);
    chk("rec_cnt", bus.sysreg_rdata, 0);
    chk("rec_pending_cleared", bus.irq_ack, 0);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 15; i++) begin
      drv4(1, 0);
      drv4(0, 1);
    end
    #1;
    chk("sat_reach", bus4.sysreg_rdata, 64'hF);
    for (int i = 0; i < 3; i++) begin
      drv4(1, 0);
      drv4(0, 1);
    end
    #1;
    chk("sat_hold", bus4.sysreg_rdata, 64'hF);
    drv4(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exc_ctrl_unit.md
Name: exc_ctrl_unit

Overview:
- Sequential exception controller directly downstream of the main decoder in the single-cycle LEGv8 core.
- Consumes the decoder's Exc, EStatus and ERet, plus the raw external IRQ and the current PC.
- Holds the exception system registers ELR, ESR and ERR, plus the handler-mode FSM.
- Drives the PC redirect to the exception vector or the return address, squashes the committing instruction, and supplies MRS read data to the datapath.

Parameters:
- N, 64, datapath/PC width.
- VECTOR_ADDR, 64'h0000_0000_0000_00D8, exception handler entry address.
- CNT_W, 16, width of the saturating exception counter held in ERR.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- exc  input  1  Exc from the main decoder.
- estatus  input  4  EStatus from the main decoder; 4'b0010 = invalid opcode.
- eret  input  1  ERet from the main decoder.
- ext_irq  input  1  raw external interrupt request, level.
- pc  input  N  address of the instruction in the current cycle.
- sysreg_sel  input  2  MRS source: 00 ELR, 01 ESR, 10 ERR, 11 zero.
- pc_redirect  output  1  forces next PC = redirect_target.
- redirect_target  output  N  VECTOR_ADDR on exception entry, ELR on ERET.
- squash  output  1  suppresses RegWrite/MemWrite/Branch of the current instruction.
- stall  output  1  holds the PC (HALT state).
- irq_ack  output  1  one-cycle pulse when an IRQ is taken.
- in_handler  output  1  high in HANDLER state.
- double_fault  output  1  high in HALT state.
- elr  output  N  exception link register.
- esr  output  4  exception syndrome (cause).
- sysreg_rdata  output  N  MRS read data, selected by sysreg_sel.

Behaviour:
- Reset (synchronous):
  - state=RUN; elr=0, esr=0, ERR count=0, irq_pending=0.
  - All pulse and redirect outputs are 0.
  - Reset overrides every other input in the same cycle, including mid-handler and HALT.
- Cause decode:
  - inv = exc && estatus==4'b0010.
  - irq_pending is set on any cycle with ext_irq=1.
  - irq_pending is cleared only in the cycle the IRQ is taken; set takes priority over clear if ext_irq is still high.
- FSM states: RUN, HANDLER, HALT.
- RUN, inv=1 (priority over IRQ):
  - Same cycle, combinational: pc_redirect=1, redirect_target=VECTOR_ADDR, squash=0 (decoder already zeroes writes).
  - At the clock edge: elr<=pc, esr<=4'b0010, count++, state<=HANDLER.
  - A coincident IRQ stays pending.
- RUN, inv=0, irq_pending|ext_irq:
  - Same cycle: pc_redirect=1, redirect_target=VECTOR_ADDR, squash=1, irq_ack=1.
  - At the clock edge: elr<=pc (instruction re-executes on return), esr<=4'b0001, count++, irq_pending<=0, state<=HANDLER.
- RUN, eret=1 with no exception: pc_redirect=1, redirect_target=elr, state stays RUN.
- HANDLER:
  - IRQs are masked; ext_irq only sets irq_pending.
  - eret=1: pc_redirect=1, redirect_target=elr, state<=RUN. A pending IRQ is taken in the first RUN cycle after return.
  - inv=1 (double fault): squash=1, state<=HALT, esr<=4'b0011, elr unchanged.
- HALT:
  - stall=1, squash=1, double_fault=1; all inputs ignored.
  - Exit only via reset.
- Latency:
  - Redirect is combinational, effective for the next fetch.
  - System registers update at the next edge.
  - MRS in the first handler instruction sees the updated values.
- Counter: ERR count is CNT_W bits and saturates at all-ones.
- Read data:
  - sysreg_rdata is combinational.
  - esr and count are zero-extended to N.

Test Plan:
- Reset, then pc=0x40, exc=1, estatus=0010 -> same cycle pc_redirect=1, target=0xD8; next cycle elr=0x40, esr=2, in_handler=1, sysreg_sel=10 reads 1.
- In RUN, ext_irq pulsed 1 cycle at pc=0x100 -> irq_ack=1, squash=1, target=0xD8; then elr=0x100, esr=1; eret -> target=0x100, in_handler=0.
- In HANDLER, ext_irq pulsed -> no redirect; on eret, return to elr, then the next cycle takes the IRQ with esr=1 and irq_ack=1.
- Same cycle inv and ext_irq in RUN -> esr=2; IRQ taken right after the first eret.
- In HANDLER, inv=1 -> HALT: stall=1, double_fault=1, esr=3; eret ignored; reset -> RUN with all registers zero.
- Force count to all-ones, take an exception -> ERR stays 0xFFFF.
